se_selfcomp_driver: RTL and testbench

Initiator and checker for self-composition timing-leak testing of the SE block. Accepts one command per transaction, carrying the shared public instruction and operands plus a distinct secret `cond` per copy. Issues the command to two SE instances through independent valid/ready handshakes, then collects both results and measures per-copy latency. Produces a per-transaction report and a sticky timing-leak flag; it sits in the self-composition test harness between the stimulus source and the two SE copies.

---
 rtl/se_selfcomp_driver.sv | 218 +++++++++++++++++++++
 tb/tb_se_selfcomp_driver.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/se_selfcomp_driver.sv
// Self-composition driver: issues one command to two SE copies, times each lane,
// and reports per-transaction latencies, results and a sticky timing-leak flag.
module se_selfcomp_driver #(
   parameter int TIMEOUT = 200
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         io_cmd_valid,
   output logic         io_cmd_ready,
   input  logic [7:0]   io_cmd_inst,
   input  logic [127:0] io_cmd_op1,
   input  logic [127:0] io_cmd_op2,
   input  logic [127:0] io_cmd_condOne,
   input  logic [127:0] io_cmd_condTwo,
   output logic         io_se1_in_valid,
   input  logic         io_se1_in_ready,
   output logic [7:0]   io_se1_in_inst,
   output logic [127:0] io_se1_in_op1,
   output logic [127:0] io_se1_in_op2,
   output logic [127:0] io_se1_in_cond,
   input  logic [127:0] io_se1_out_result,
   input  logic         io_se1_out_valid,
   output logic         io_se1_out_ready,
   output logic         io_se2_in_valid,
   input  logic         io_se2_in_ready,
   output logic [7:0]   io_se2_in_inst,
   output logic [127:0] io_se2_in_op1,
   output logic [127:0] io_se2_in_op2,
   output logic [127:0] io_se2_in_cond,
   input  logic [127:0] io_se2_out_result,
   input  logic         io_se2_out_valid,
   output logic         io_se2_out_ready,
   output logic         io_rpt_valid,
   input  logic         io_rpt_ready,
   output logic [127:0] io_rpt_resultOne,
   output logic [127:0] io_rpt_resultTwo,
   output logic [7:0]   io_rpt_latencyOne,
   output logic [7:0]   io_rpt_latencyTwo,
   output logic         io_rpt_resultMatch,
   output logic         io_rpt_leak,
   output logic         io_rpt_timeout,
   output logic         io_timingLeak,
   output logic         io_timingLeakDone,
   output logic         io_bothValid
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t       state;
   logic [7:0]   inst_q;
   logic [127:0] op1_q, op2_q, cond_one_q, cond_two_q;

   logic [1:0]   issued, done;
   logic [7:0]   cnt [2];
   logic [127:0] res [2];
   logic         tmo;

   logic [1:0]   issued_n, done_n;
   logic [7:0]   cnt_n [2];
   logic [127:0] res_n [2];
   logic         tmo_n;

   logic [1:0]   in_valid, in_ready, out_valid, out_ready;
   logic [127:0] out_result [2];
   logic         active;

   logic [127:0] rpt_res_one, rpt_res_two;
   logic [7:0]   rpt_lat_one, rpt_lat_two;
   logic         rpt_match, rpt_leak, rpt_tmo, timing_leak;

   assign active        = (state == ISSUE) || (state == WAIT);
   assign in_ready      = {io_se2_in_ready, io_se1_in_ready};
   assign out_valid     = {io_se2_out_valid, io_se1_out_valid};
   assign out_result[0] = io_se1_out_result;
   assign out_result[1] = io_se2_out_result;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         in_valid[i]  = (state == ISSUE) && !issued[i];
         out_ready[i] = active && issued[i] && !done[i];
      end
   end

   // Next-state lane bookkeeping; in/out handshakes on one lane are exclusive
   // because out_ready needs the registered issued flag.
   always_comb begin
      issued_n = issued;
      done_n   = done;
      tmo_n    = tmo;
      for (int i = 0; i < 2; i++) begin
         cnt_n[i] = cnt[i];
         res_n[i] = res[i];
         if (in_valid[i] && in_ready[i]) begin
            issued_n[i] = 1'b1;
            cnt_n[i]    = 8'd0;
         end else if (out_ready[i] && out_valid[i]) begin
            done_n[i] = 1'b1;
            res_n[i]  = out_result[i];
            cnt_n[i]  = (cnt[i] == 8'hFF) ? 8'hFF : cnt[i] + 8'd1;
         end else if (active && issued[i] && !done[i]) begin
            if (cnt[i] == TIMEOUT_CNT) begin
               done_n[i] = 1'b1;
               res_n[i]  = '0;
               tmo_n     = 1'b1;
            end else begin
               cnt_n[i] = (cnt[i] == 8'hFF) ? 8'hFF : cnt[i] + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         inst_q      <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         cond_one_q  <= '0;
         cond_two_q  <= '0;
         issued      <= '0;
         done        <= '0;
         tmo         <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            cnt[i] <= '0;
            res[i] <= '0;
         end
         rpt_res_one <= '0;
         rpt_res_two <= '0;
         rpt_lat_one <= '0;
         rpt_lat_two <= '0;
         rpt_match   <= 1'b0;
         rpt_leak    <= 1'b0;
         rpt_tmo     <= 1'b0;
         timing_leak <= 1'b0;
      end else begin
         if (active) begin
            issued <= issued_n;
            done   <= done_n;
            tmo    <= tmo_n;
            for (int i = 0; i < 2; i++) begin
               cnt[i] <= cnt_n[i];
               res[i] <= res_n[i];
            end
         end
         case (state)
            IDLE: begin
               if (io_cmd_valid) begin
                  inst_q     <= io_cmd_inst;
                  op1_q      <= io_cmd_op1;
                  op2_q      <= io_cmd_op2;
                  cond_one_q <= io_cmd_condOne;
                  cond_two_q <= io_cmd_condTwo;
                  issued     <= '0;
                  done       <= '0;
                  tmo        <= 1'b0;
                  for (int i = 0; i < 2; i++) begin
                     cnt[i] <= '0;
                     res[i] <= '0;
                  end
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (&issued_n) state <= WAIT;
            end
            WAIT: begin
               // Snapshot from next-state values so the report appears the
               // cycle after the second lane completes.
               if (&done_n) begin
                  rpt_res_one <= res_n[0];
                  rpt_res_two <= res_n[1];
                  rpt_lat_one <= cnt_n[0];
                  rpt_lat_two <= cnt_n[1];
                  rpt_match   <= (res_n[0] == res_n[1]);
                  rpt_leak    <= (cnt_n[0] != cnt_n[1]) || tmo_n;
                  rpt_tmo     <= tmo_n;
                  state       <= REPORT;
               end
            end
            REPORT: begin
               if (io_rpt_ready) begin
                  timing_leak <= timing_leak | rpt_leak;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign io_cmd_ready       = (state == IDLE);
   assign io_se1_in_valid    = in_valid[0];
   assign io_se2_in_valid    = in_valid[1];
   assign io_se1_out_ready   = out_ready[0];
   assign io_se2_out_ready   = out_ready[1];
   assign io_se1_in_inst     = inst_q;
   assign io_se1_in_op1      = op1_q;
   assign io_se1_in_op2      = op2_q;
   assign io_se1_in_cond     = cond_one_q;
   assign io_se2_in_inst     = inst_q;
   assign io_se2_in_op1      = op1_q;
   assign io_se2_in_op2      = op2_q;
   assign io_se2_in_cond     = cond_two_q;
   assign io_rpt_valid       = (state == REPORT);
   assign io_rpt_resultOne   = rpt_res_one;
   assign io_rpt_resultTwo   = rpt_res_two;
   assign io_rpt_latencyOne  = rpt_lat_one;
   assign io_rpt_latencyTwo  = rpt_lat_two;
   assign io_rpt_resultMatch = rpt_match;
   assign io_rpt_leak        = rpt_leak;
   assign io_rpt_timeout     = rpt_tmo;
   assign io_timingLeak      = timing_leak;
   assign io_timingLeakDone  = (state == REPORT) && io_rpt_ready;
   assign io_bothValid       = io_se1_out_valid & io_se2_out_valid;

endmodule

// File: tb/tb_se_selfcomp_driver.sv
// Directed bench for se_selfcomp_driver: two scripted SE responders with
// per-lane accept/response delays and hand-computed report expectations.
module tb_se_selfcomp_driver;

   logic         clock = 1'b0;
   logic         reset;
   logic         cmd_valid, cmd_ready;
   logic [7:0]   cmd_inst;
   logic [127:0] cmd_op1, cmd_op2, cmd_cond_one, cmd_cond_two;
   logic         se_in_ready [2];
   logic         se_out_valid [2];
   logic [127:0] se_result [2];
   logic         dut_in_valid [2];
   logic         dut_out_ready [2];
   logic [7:0]   se1_inst, se2_inst;
   logic [127:0] se1_op1, se1_op2, se1_cond, se2_op1, se2_op2, se2_cond;
   logic         rpt_valid, rpt_ready;
   logic [127:0] rpt_res_one, rpt_res_two;
   logic [7:0]   rpt_lat_one, rpt_lat_two;
   logic         rpt_match, rpt_leak, rpt_tmo;
   logic         timing_leak, timing_leak_done, both_valid;

   int           acc_dly [2];
   int           rsp_dly [2];
   bit           never_rsp [2];
   bit           early_valid [2];
   logic [127:0] rsp_val [2];

   int tests = 0;
   int failed = 0;

   always #5 clock = ~clock;

   se_selfcomp_driver #(.TIMEOUT(200)) dut (
      .clock(clock), .reset(reset),
      .io_cmd_valid(cmd_valid), .io_cmd_ready(cmd_ready),
      .io_cmd_inst(cmd_inst), .io_cmd_op1(cmd_op1), .io_cmd_op2(cmd_op2),
      .io_cmd_condOne(cmd_cond_one), .io_cmd_condTwo(cmd_cond_two),
      .io_se1_in_valid(dut_in_valid[0]), .io_se1_in_ready(se_in_ready[0]),
      .io_se1_in_inst(se1_inst), .io_se1_in_op1(se1_op1),
      .io_se1_in_op2(se1_op2), .io_se1_in_cond(se1_cond),
      .io_se1_out_result(se_result[0]), .io_se1_out_valid(se_out_valid[0]),
      .io_se1_out_ready(dut_out_ready[0]),
      .io_se2_in_valid(dut_in_valid[1]), .io_se2_in_ready(se_in_ready[1]),
      .io_se2_in_inst(se2_inst), .io_se2_in_op1(se2_op1),
      .io_se2_in_op2(se2_op2), .io_se2_in_cond(se2_cond),
      .io_se2_out_result(se_result[1]), .io_se2_out_valid(se_out_valid[1]),
      .io_se2_out_ready(dut_out_ready[1]),
      .io_rpt_valid(rpt_valid), .io_rpt_ready(rpt_ready),
      .io_rpt_resultOne(rpt_res_one), .io_rpt_resultTwo(rpt_res_two),
      .io_rpt_latencyOne(rpt_lat_one), .io_rpt_latencyTwo(rpt_lat_two),
      .io_rpt_resultMatch(rpt_match), .io_rpt_leak(rpt_leak),
      .io_rpt_timeout(rpt_tmo), .io_timingLeak(timing_leak),
      .io_timingLeakDone(timing_leak_done), .io_bothValid(both_valid)
   );

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scripted SE copy: accepts after acc_dly cycles of in_valid, answers
   // rsp_dly cycles after its own accept (optionally a spurious early valid).
   task automatic runLane(input int i);
      int waited = 0;
      forever begin
         @(negedge clock);
         if (dut_in_valid[i] && !reset) begin
            if (waited == acc_dly[i]) begin
               waited = 0;
               se_in_ready[i] = 1'b1;
               if (early_valid[i]) begin
                  se_out_valid[i] = 1'b1;
                  se_result[i]    = 128'hDEAD;
               end
               @(negedge clock);
               se_in_ready[i]  = 1'b0;
               se_out_valid[i] = 1'b0;
               if (!never_rsp[i]) begin
                  repeat (rsp_dly[i] - 1) @(negedge clock);
                  se_out_valid[i] = 1'b1;
                  se_result[i]    = rsp_val[i];
                  @(negedge clock);
                  se_out_valid[i] = 1'b0;
               end
            end else begin
               waited++;
            end
         end else begin
            waited = 0;
         end
      end
   endtask

   initial runLane(0);
   initial runLane(1);

   task automatic setLanes(input int a0, input int a1, input int r0, input int r1,
                           input logic [127:0] v0, input logic [127:0] v1);
      acc_dly[0] = a0; acc_dly[1] = a1;
      rsp_dly[0] = r0; rsp_dly[1] = r1;
      rsp_val[0] = v0; rsp_val[1] = v1;
      never_rsp[0] = 1'b0; never_rsp[1] = 1'b0;
      early_valid[0] = 1'b0; early_valid[1] = 1'b0;
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the first ISSUE cycle.
   task automatic applyStimulus(input logic [7:0] inst, input logic [127:0] op1,
                                input logic [127:0] op2, input logic [127:0] c1,
                                input logic [127:0] c2);
      checkOutput("cmd_ready_idle", 128'(cmd_ready), 128'd1);
      cmd_valid = 1'b1; cmd_inst = inst; cmd_op1 = op1; cmd_op2 = op2;
      cmd_cond_one = c1; cmd_cond_two = c2;
      @(posedge clock);
      #1 cmd_valid = 1'b0;
      @(negedge clock);
      checkOutput("se1_in_valid_t1", 128'(dut_in_valid[0]), 128'd1);
      checkOutput("se2_in_valid_t1", 128'(dut_in_valid[1]), 128'd1);
      checkOutput("se1_inst", 128'(se1_inst), 128'(inst));
      checkOutput("se2_op1", se2_op1, op1);
      checkOutput("se1_op2", se1_op2, op2);
      checkOutput("se1_cond", se1_cond, c1);
      checkOutput("se2_cond", se2_cond, c2);
      checkOutput("cmd_ready_busy", 128'(cmd_ready), 128'd0);
   endtask

   task automatic waitReport(input string tag, input int exp_cycles);
      int cycles = 1;
      while (!rpt_valid && cycles < 400) begin
         @(negedge clock);
         cycles++;
      end
      checkOutput({tag, "_rpt_cycles"}, 128'(cycles), 128'(exp_cycles));
   endtask

   task automatic checkReport(input string tag, input logic [127:0] r1, input logic [127:0] r2,
                              input int l1, input int l2, input bit m, input bit lk, input bit to);
      checkOutput({tag, "_rpt_valid"}, 128'(rpt_valid), 128'd1);
      checkOutput({tag, "_res1"}, rpt_res_one, r1);
      checkOutput({tag, "_res2"}, rpt_res_two, r2);
      checkOutput({tag, "_lat1"}, 128'(rpt_lat_one), 128'(l1));
      checkOutput({tag, "_lat2"}, 128'(rpt_lat_two), 128'(l2));
      checkOutput({tag, "_match"}, 128'(rpt_match), 128'(m));
      checkOutput({tag, "_leak"}, 128'(rpt_leak), 128'(lk));
      checkOutput({tag, "_timeout"}, 128'(rpt_tmo), 128'(to));
   endtask

   task automatic consumeReport(input string tag, input bit exp_sticky);
      rpt_ready = 1'b1;
      #1 checkOutput({tag, "_done_pulse"}, 128'(timing_leak_done), 128'd1);
      @(posedge clock);
      #1 rpt_ready = 1'b0;
      @(negedge clock);
      checkOutput({tag, "_done_low"}, 128'(timing_leak_done), 128'd0);
      checkOutput({tag, "_sticky"}, 128'(timing_leak), 128'(exp_sticky));
      checkOutput({tag, "_cmd_ready"}, 128'(cmd_ready), 128'd1);
      checkOutput({tag, "_rpt_valid_low"}, 128'(rpt_valid), 128'd0);
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; rpt_ready = 1'b0;
      cmd_inst = '0; cmd_op1 = '0; cmd_op2 = '0; cmd_cond_one = '0; cmd_cond_two = '0;
      for (int i = 0; i < 2; i++) begin
         se_in_ready[i] = 1'b0; se_out_valid[i] = 1'b0; se_result[i] = '0;
      end
      setLanes(0, 0, 3, 3, 128'h0, 128'h0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);

      checkOutput("rst_cmd_ready", 128'(cmd_ready), 128'd1);
      checkOutput("rst_se1_in_valid", 128'(dut_in_valid[0]), 128'd0);
      checkOutput("rst_se2_out_ready", 128'(dut_out_ready[1]), 128'd0);
      checkOutput("rst_rpt_valid", 128'(rpt_valid), 128'd0);
      checkOutput("rst_timing_leak", 128'(timing_leak), 128'd0);

      se_out_valid[0] = 1'b1; se_out_valid[1] = 1'b1;
      #1 checkOutput("both_valid_11", 128'(both_valid), 128'd1);
      se_out_valid[1] = 1'b0;
      #1 checkOutput("both_valid_10", 128'(both_valid), 128'd0);
      se_out_valid[0] = 1'b0;
      @(negedge clock);

      // Equal latencies, equal results.
      setLanes(0, 0, 3, 3, 128'hCAFE, 128'hCAFE);
      applyStimulus(8'h11, 128'h1, 128'h2, 128'h3, 128'h4);
      waitReport("t1", 5);
      checkReport("t1", 128'hCAFE, 128'hCAFE, 3, 3, 1'b1, 1'b0, 1'b0);
      consumeReport("t1", 1'b0);

      // Unequal latencies 3/5 set the sticky leak.
      setLanes(0, 0, 3, 5, 128'h5, 128'h6);
      applyStimulus(8'h22, 128'hA0, 128'hB0, 128'hC0, 128'hD0);
      waitReport("t2", 7);
      checkReport("t2", 128'h5, 128'h6, 3, 5, 1'b0, 1'b1, 1'b0);
      consumeReport("t2", 1'b1);

      // SE1 accepts two cycles late, equal latency 4: clean, sticky stays set.
      setLanes(2, 0, 4, 4, 128'h7, 128'h7);
      applyStimulus(8'h33, 128'h11, 128'h22, 128'h33, 128'h44);
      waitReport("t3", 8);
      checkReport("t3", 128'h7, 128'h7, 4, 4, 1'b1, 1'b0, 1'b0);
      consumeReport("t3", 1'b1);

      // SE2 never answers: forced done at TIMEOUT.
      setLanes(0, 0, 3, 3, 128'h9, 128'h9);
      never_rsp[1] = 1'b1;
      applyStimulus(8'h44, 128'h5, 128'h6, 128'h7, 128'h8);
      waitReport("t4", 203);
      checkReport("t4", 128'h9, 128'h0, 3, 200, 1'b0, 1'b1, 1'b1);
      consumeReport("t4", 1'b1);

      // Spurious out_valid during SE1's accept cycle is ignored.
      setLanes(0, 0, 2, 2, 128'h42, 128'h42);
      early_valid[0] = 1'b1;
      applyStimulus(8'h55, 128'h1, 128'h1, 128'h2, 128'h3);
      waitReport("t6", 4);
      checkReport("t6", 128'h42, 128'h42, 2, 2, 1'b1, 1'b0, 1'b0);
      consumeReport("t6", 1'b1);

      // Report back-pressure: fields hold while rpt_ready is low.
      setLanes(0, 0, 1, 1, 128'h1, 128'h1);
      applyStimulus(8'h66, 128'h9, 128'h9, 128'h9, 128'h9);
      waitReport("t5", 3);
      for (int k = 0; k < 4; k++) begin
         checkReport("t5_hold", 128'h1, 128'h1, 1, 1, 1'b1, 1'b0, 1'b0);
         checkOutput("t5_hold_cmd_ready", 128'(cmd_ready), 128'd0);
         checkOutput("t5_hold_done", 128'(timing_leak_done), 128'd0);
         @(negedge clock);
      end
      consumeReport("t5", 1'b1);

      // Reset in the middle of WAIT.
      setLanes(0, 0, 20, 20, 128'h3, 128'h3);
      applyStimulus(8'h77, 128'hF1, 128'hF2, 128'hF3, 128'hF4);
      repeat (4) @(negedge clock);
      checkOutput("rst_mid_out_ready", 128'(dut_out_ready[0]), 128'd1);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      checkOutput("rst_mid_cmd_ready", 128'(cmd_ready), 128'd1);
      checkOutput("rst_mid_se1_in_valid", 128'(dut_in_valid[0]), 128'd0);
      checkOutput("rst_mid_se1_out_ready", 128'(dut_out_ready[0]), 128'd0);
      checkOutput("rst_mid_se2_out_ready", 128'(dut_out_ready[1]), 128'd0);
      checkOutput("rst_mid_inst", 128'(se1_inst), 128'd0);
      checkOutput("rst_mid_op1", se2_op1, 128'd0);
      checkOutput("rst_mid_cond", se1_cond, 128'd0);
      checkOutput("rst_mid_rpt_valid", 128'(rpt_valid), 128'd0);
      checkOutput("rst_mid_lat1", 128'(rpt_lat_one), 128'd0);
      checkOutput("rst_mid_res1", rpt_res_one, 128'd0);
      checkOutput("rst_mid_leak", 128'(rpt_leak), 128'd0);
      checkOutput("rst_mid_timing_leak", 128'(timing_leak), 128'd0);
      checkOutput("rst_mid_done", 128'(timing_leak_done), 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
